// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: IFU reads and LSU loads/stores share one downstream port.
// LSU has priority, but IFU is granted after STARVE_LIMIT consecutive LSU grants.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_req,
    input  logic [31:0] ifu_addr,
    output logic        ifu_ready,
    output logic        ifu_rvalid,
    output logic [31:0] ifu_rdata,
    input  logic        lsu_req,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_ready,
    output logic        lsu_rvalid,
    output logic [31:0] lsu_rdata,
    output logic        mem_req,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state_q, state_d;
    logic             owner_lsu_q, owner_lsu_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             mem_wen_q, mem_wen_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic [3:0]       mem_wmask_q, mem_wmask_d;
    logic [31:0]      ifu_rdata_q, ifu_rdata_d;
    logic [31:0]      lsu_rdata_q, lsu_rdata_d;
    logic             ifu_grant, lsu_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_lsu_q <= 1'b0;
            starve_q    <= '0;
            mem_wen_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_lsu_q <= owner_lsu_d;
            starve_q    <= starve_d;
            mem_wen_q   <= mem_wen_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wmask_q <= mem_wmask_d;
            ifu_rdata_q <= ifu_rdata_d;
            lsu_rdata_q <= lsu_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_lsu_d = owner_lsu_q;
        starve_d    = starve_q;
        mem_wen_d   = mem_wen_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wmask_d = mem_wmask_q;
        ifu_rdata_d = ifu_rdata_q;
        lsu_rdata_d = lsu_rdata_q;
        ifu_grant   = 1'b0;
        lsu_grant   = 1'b0;

        case (state_q)
            IDLE: begin
                ifu_grant = ifu_req && (!lsu_req || (starve_q == CNT_MAX));
                lsu_grant = lsu_req && !ifu_grant;
                if (ifu_grant) begin
                    owner_lsu_d = 1'b0;
                    mem_wen_d   = 1'b0;
                    mem_addr_d  = ifu_addr;
                    mem_wdata_d = '0;
                    mem_wmask_d = '0;
                    starve_d    = '0;
                    state_d     = ISSUE;
                end else if (lsu_grant) begin
                    owner_lsu_d = 1'b1;
                    mem_wen_d   = lsu_wen;
                    mem_addr_d  = lsu_addr;
                    mem_wdata_d = lsu_wen ? lsu_wdata : '0;
                    mem_wmask_d = lsu_wen ? lsu_wmask : '0;
                    if (!ifu_req)
                        starve_d = '0;
                    else if (starve_q != CNT_MAX)
                        starve_d = starve_q + 1'b1;
                    // A store that writes no bytes completes without touching memory.
                    if (lsu_wen && (lsu_wmask == 4'b0000)) begin
                        lsu_rdata_d = '0;
                        state_d     = RESP;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (mem_ready)
                    state_d = WAIT;
            end
            WAIT: begin
                if (mem_rvalid) begin
                    if (owner_lsu_q)
                        lsu_rdata_d = mem_wen_q ? '0 : mem_rdata;
                    else
                        ifu_rdata_d = mem_rdata;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Every output is forced low while reset is held, even before the flops clear.
    always_comb begin
        ifu_ready  = ifu_grant && !rst;
        lsu_ready  = lsu_grant && !rst;
        ifu_rvalid = !rst && (state_q == RESP) && !owner_lsu_q;
        lsu_rvalid = !rst && (state_q == RESP) && owner_lsu_q;
        ifu_rdata  = rst ? '0 : ifu_rdata_q;
        lsu_rdata  = rst ? '0 : lsu_rdata_q;
        mem_req    = !rst && (state_q == ISSUE);
        mem_wen    = rst ? 1'b0 : mem_wen_q;
        mem_addr   = rst ? '0 : mem_addr_q;
        mem_wdata  = rst ? '0 : mem_wdata_q;
        mem_wmask  = rst ? '0 : mem_wmask_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expectations into queues,
// a monitor and a memory responder pop and compare them as the DUT responds.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req, ifu_ready, ifu_rvalid;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req, lsu_wen, lsu_ready, lsu_rvalid;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wmask;
    logic        mem_req, mem_wen, mem_ready, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_ready(ifu_ready),
        .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
        .lsu_req(lsu_req), .lsu_wen(lsu_wen), .lsu_addr(lsu_addr),
        .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask), .lsu_ready(lsu_ready),
        .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
        .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    typedef struct packed {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } mem_t;

    mem_t        exp_mem[$];
    logic [31:0] exp_ifu[$];
    logic [31:0] exp_lsu[$];
    logic [31:0] resp_q[$];
    logic        exp_grant[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ready_delay = 0;
    int rvalid_delay = 1;
    int last_ifu_rv_cyc = -1;
    int last_lsu_rv_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s actual=event required=none", name);
    endtask

    // Monitor: grants and responses are matched against the scoreboard queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (ifu_ready || lsu_ready) begin
                check("one_ready", {31'b0, ifu_ready & lsu_ready}, 32'd0);
                if (exp_grant.size() == 0) fail("grant_unexpected");
                else check("grant_owner", {31'b0, lsu_ready}, {31'b0, exp_grant.pop_front()});
            end
            if (ifu_rvalid) begin
                last_ifu_rv_cyc = cyc;
                if (exp_ifu.size() == 0) fail("ifu_rvalid_unexpected");
                else check("ifu_rdata", ifu_rdata, exp_ifu.pop_front());
            end
            if (lsu_rvalid) begin
                last_lsu_rv_cyc = cyc;
                if (exp_lsu.size() == 0) fail("lsu_rvalid_unexpected");
                else check("lsu_rdata", lsu_rdata, exp_lsu.pop_front());
            end
        end
    end

    // Memory responder: checks the issued payload, stalls, then answers.
    initial begin
        mem_t e;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (mem_req && !rst) begin
                if (exp_mem.size() == 0) begin
                    fail("mem_unexpected");
                    e = '0;
                end else begin
                    e = exp_mem.pop_front();
                    check("mem_wen", {31'b0, mem_wen}, {31'b0, e.wen});
                    check("mem_addr", mem_addr, e.addr);
                    check("mem_wmask", {28'b0, mem_wmask}, {28'b0, e.wmask});
                    if (e.wen) check("mem_wdata", mem_wdata, e.wdata);
                end
                for (int i = 0; i < ready_delay; i++) begin
                    @(negedge clk);
                    check("mem_req_stall", {31'b0, mem_req}, 32'd1);
                    check("mem_addr_stall", mem_addr, e.addr);
                    check("mem_wmask_stall", {28'b0, mem_wmask}, {28'b0, e.wmask});
                end
                mem_ready = 1'b1;
                @(negedge clk);
                mem_ready = 1'b0;
                check("mem_req_wait", {31'b0, mem_req}, 32'd0);
                for (int i = 1; i < rvalid_delay; i++) begin
                    @(negedge clk);
                    check("mem_req_wait", {31'b0, mem_req}, 32'd0);
                end
                mem_rvalid = 1'b1;
                mem_rdata  = (resp_q.size() != 0) ? resp_q.pop_front() : 32'hBAD0BAD0;
                @(negedge clk);
                mem_rvalid = 1'b0;
            end
        end
    end

    task automatic applyIfu(input logic [31:0] addr, output int acc);
        int n;
        n = 0;
        acc = -1;
        @(posedge clk); #1;
        ifu_req  = 1'b1;
        ifu_addr = addr;
        forever begin
            @(negedge clk);
            if (ifu_ready) break;
            n++;
            if (n > 200) begin fail("ifu_grant_timeout"); break; end
        end
        acc = cyc;
        @(posedge clk); #1;
        ifu_req = 1'b0;
    endtask

    task automatic applyLsu(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wmask, output int acc);
        int n;
        n = 0;
        acc = -1;
        @(posedge clk); #1;
        lsu_req   = 1'b1;
        lsu_wen   = wen;
        lsu_addr  = addr;
        lsu_wdata = wdata;
        lsu_wmask = wmask;
        forever begin
            @(negedge clk);
            if (lsu_ready) break;
            n++;
            if (n > 200) begin fail("lsu_grant_timeout"); break; end
        end
        acc = cyc;
        @(posedge clk); #1;
        lsu_req = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_ifu.size() + exp_lsu.size() + exp_mem.size() + exp_grant.size()) != 0) begin
            @(negedge clk);
            n++;
            if (n > 100) begin
                fail("drain_timeout");
                exp_ifu.delete(); exp_lsu.delete(); exp_mem.delete(); exp_grant.delete();
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, "_ready"}, {30'b0, ifu_ready, lsu_ready}, 32'd0);
        check({tag, "_rvalid"}, {30'b0, ifu_rvalid, lsu_rvalid}, 32'd0);
        check({tag, "_mem_req"}, {30'b0, mem_req, mem_wen}, 32'd0);
        check({tag, "_mem_addr"}, mem_addr | mem_wdata | {28'b0, mem_wmask}, 32'd0);
        check({tag, "_rdata"}, ifu_rdata | lsu_rdata, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int a0, a1, a_ifu, a_lsu0;
        rst = 1'b1;
        ifu_req = 1'b1; ifu_addr = 32'h8000_0000;
        lsu_req = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h8000_0010;
        lsu_wdata = 32'h1234_5678; lsu_wmask = 4'hF;

        // Reset with both requesters active: nothing granted, everything low.
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        @(posedge clk); #1;
        ifu_req = 1'b0; lsu_req = 1'b0; rst = 1'b0;
        @(negedge clk);
        checkResetOutputs("post_reset");

        // Single IFU read at minimum latency.
        exp_grant.push_back(1'b0);
        exp_mem.push_back('{1'b0, 32'h8000_0000, 32'h0, 4'h0});
        resp_q.push_back(32'h0000_0413);
        exp_ifu.push_back(32'h0000_0413);
        applyIfu(32'h8000_0000, a0);
        drain();
        check("ifu_latency", 32'(last_ifu_rv_cyc - a0), 32'd3);

        // Simultaneous requests: LSU store wins, IFU follows on the next IDLE.
        exp_grant.push_back(1'b1);
        exp_grant.push_back(1'b0);
        exp_mem.push_back('{1'b1, 32'h8000_8FF0, 32'hDEAD_BEEF, 4'hF});
        exp_mem.push_back('{1'b0, 32'h8000_0004, 32'h0, 4'h0});
        resp_q.push_back(32'hFFFF_FFFF);
        resp_q.push_back(32'h0010_0093);
        exp_lsu.push_back(32'h0);
        exp_ifu.push_back(32'h0010_0093);
        fork
            applyLsu(1'b1, 32'h8000_8FF0, 32'hDEAD_BEEF, 4'hF, a0);
            applyIfu(32'h8000_0004, a1);
        join
        drain();
        check("regrant_gap", 32'(a1 - a0), 32'd4);
        check("ifu_rdata_hold", ifu_rdata, 32'h0010_0093);

        // Starvation: four LSU loads, then IFU, then the fifth load.
        for (int i = 0; i < 4; i++) begin
            exp_grant.push_back(1'b1);
            exp_mem.push_back('{1'b0, 32'h8000_1000 + 32'(4 * i), 32'h0, 4'h0});
            resp_q.push_back(32'h0000_1000 + 32'(i));
            exp_lsu.push_back(32'h0000_1000 + 32'(i));
        end
        exp_grant.push_back(1'b0);
        exp_mem.push_back('{1'b0, 32'h8000_0100, 32'h0, 4'h0});
        resp_q.push_back(32'h0000_0113);
        exp_ifu.push_back(32'h0000_0113);
        exp_grant.push_back(1'b1);
        exp_mem.push_back('{1'b0, 32'h8000_1010, 32'h0, 4'h0});
        resp_q.push_back(32'h0000_1004);
        exp_lsu.push_back(32'h0000_1004);
        fork
            begin
                int t;
                for (int i = 0; i < 5; i++) begin
                    applyLsu(1'b0, 32'h8000_1000 + 32'(4 * i), 32'h0, 4'hF, t);
                    if (i == 0) a_lsu0 = t;
                end
            end
            applyIfu(32'h8000_0100, a_ifu);
        join
        drain();
        check("starve_ifu_cycle", 32'(a_ifu - a_lsu0), 32'd16);

        // Stalled handshake: unaligned load, then partial store.
        ready_delay = 3;
        rvalid_delay = 5;
        exp_grant.push_back(1'b1);
        exp_mem.push_back('{1'b0, 32'h8000_2002, 32'h0, 4'h0});
        resp_q.push_back(32'hCAFE_F00D);
        exp_lsu.push_back(32'hCAFE_F00D);
        applyLsu(1'b0, 32'h8000_2002, 32'h5555_5555, 4'hF, a0);
        drain();
        exp_grant.push_back(1'b1);
        exp_mem.push_back('{1'b1, 32'h8000_3001, 32'h1122_3344, 4'b0101});
        resp_q.push_back(32'h7777_7777);
        exp_lsu.push_back(32'h0);
        applyLsu(1'b1, 32'h8000_3001, 32'h1122_3344, 4'b0101, a0);
        drain();
        ready_delay = 0;
        rvalid_delay = 1;

        // Zero-mask store completes one cycle after acceptance without memory traffic.
        exp_grant.push_back(1'b1);
        exp_lsu.push_back(32'h0);
        applyLsu(1'b1, 32'h8000_4000, 32'hAAAA_AAAA, 4'b0000, a0);
        for (int i = 0; i < 4; i++) begin
            check("zero_mask_no_mem_req", {31'b0, mem_req}, 32'd0);
            @(negedge clk);
        end
        drain();
        check("zero_mask_latency", 32'(last_lsu_rv_cyc - a0), 32'd1);

        // Reset while waiting for data: the late response must be dropped.
        rvalid_delay = 6;
        exp_grant.push_back(1'b0);
        exp_mem.push_back('{1'b0, 32'h8000_0200, 32'h0, 4'h0});
        resp_q.push_back(32'hBADB_AD00);
        applyIfu(32'h8000_0200, a0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checkResetOutputs("mid_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("stray_rvalid_ifu", {31'b0, ifu_rvalid}, 32'd0);
        rvalid_delay = 1;
        exp_grant.push_back(1'b1);
        exp_mem.push_back('{1'b0, 32'h8000_5000, 32'h0, 4'h0});
        resp_q.push_back(32'h55AA_55AA);
        exp_lsu.push_back(32'h55AA_55AA);
        applyLsu(1'b0, 32'h8000_5000, 32'h0, 4'hF, a0);
        drain();
        check("lsu_rdata_hold", lsu_rdata, 32'h55AA_55AA);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
